// File: rtl/wtm_pkg.sv
// rtl/wtm_pkg.sv - shared constants and Wallace-tree sizing helpers for wtm_pipe_mult
package wtm_pkg;

  localparam int WTM_LATENCY = 3;

  // Rows left after one level of 3:2 compression: each full group of three becomes two rows,
  // and the one or two leftover rows pass through unchanged.
  function automatic int wtm_next_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int wtm_rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) begin
      r = wtm_next_rows(r);
    end
    return r;
  endfunction

  function automatic int wtm_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = wtm_next_rows(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/wtm_pipe_mult_if.sv
// rtl/wtm_pipe_mult_if.sv - operand/product handshake bundle for wtm_pipe_mult
interface wtm_pipe_mult_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p
  );

endinterface

// File: rtl/wtm_csa_row.sv
// rtl/wtm_csa_row.sv - one row of N 3:2 compressors; carry row is returned already shifted left
module wtm_csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  assign s = x ^ y ^ z;

  // The carry out of the top column falls off: the product is defined modulo 2^N.
  assign c = {(x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]), 1'b0};

endmodule

// File: rtl/wtm_pipe_mult.sv
// rtl/wtm_pipe_mult.sv - three-stage pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed
module wtm_pipe_mult
  import wtm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  wtm_pipe_mult_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;
  localparam int LV = wtm_levels(NR);
  localparam logic [PW-1:0] BW_ONES = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } cs_t;

  logic             adv;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic             v0_q, v0_d;
  cs_t              cs_q, cs_d;
  logic             v1_q, v1_d;
  logic [PW-1:0]    p_q, p_d;
  logic             ov_q, ov_d;

  logic [PW-1:0]    tree [LV+1][NR];

  assign adv           = !ov_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = ov_q;
  assign bus.p         = p_q;

  // Row i holds a[j]&b[i] at weight i+j; in signed mode the cross terms against a single
  // sign bit are inverted and the two correction ones go in an extra row.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [WIDTH-1:0] bits;
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      localparam bit INV = (i == WIDTH - 1) != (j == WIDTH - 1);
      assign bits[j] = (a_q[j] & b_q[i]) ^ (sm_q & INV);
    end
    assign tree[0][i] = PW'(bits) << i;
  end
  assign tree[0][WIDTH] = sm_q ? BW_ONES : '0;

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int RI = wtm_rows_at(NR, l);
    localparam int G  = RI / 3;
    localparam int R  = RI % 3;

    for (genvar g = 0; g < G; g++) begin : g_grp
      wtm_csa_row #(.N(PW)) u_csa (
        .x (tree[l][3*g]),
        .y (tree[l][3*g+1]),
        .z (tree[l][3*g+2]),
        .s (tree[l+1][2*g]),
        .c (tree[l+1][2*g+1])
      );
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign tree[l+1][2*G+r] = tree[l][3*G+r];
    end

    for (genvar r = 2 * G + R; r < NR; r++) begin : g_pad
      assign tree[l+1][r] = '0;
    end
  end

  // Every stage moves together on adv, so a stall also freezes bubbles in place.
  always_comb begin : next_state
    a_d  = a_q;
    b_d  = b_q;
    sm_d = sm_q;
    v0_d = v0_q;
    cs_d = cs_q;
    v1_d = v1_q;
    p_d  = p_q;
    ov_d = ov_q;
    if (adv) begin
      a_d       = bus.a;
      b_d       = bus.b;
      sm_d      = bus.signed_mode;
      v0_d      = bus.in_valid;
      cs_d.sum   = tree[LV][0];
      cs_d.carry = tree[LV][1];
      v1_d      = v0_q;
      p_d       = cs_q.sum + cs_q.carry;
      ov_d      = v1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stage_regs
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      sm_q <= 1'b0;
      v0_q <= 1'b0;
      cs_q <= '0;
      v1_q <= 1'b0;
      p_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      sm_q <= sm_d;
      v0_q <= v0_d;
      cs_q <= cs_d;
      v1_q <= v1_d;
      p_q  <= p_d;
      ov_q <= ov_d;
    end
  end

endmodule
